sr_4094_shifter: RTL and testbench
==================================

SR_4094_SHIFTER -- requirements
Module: sr_4094_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 24: number of bits shifted into the 4094 chain per transfer (3 daisy-chained 4094s).
REQ-002 SHALL have parameter CLK_DIV, default 4: half-period of sr_clk in clk cycles; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge on clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request that begins a transfer.
REQ-006 SHALL have port data, input, WIDTH bits: the parallel word to shift out, sampled on the cycle start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle pulse when a transfer completes.
REQ-009 SHALL have port sr_clk, output, 1 bit: the 4094 CLK; the 4094 samples it on the rising edge.
REQ-010 SHALL have port sr_data, output, 1 bit: the 4094 serial DATA.
REQ-011 SHALL have port sr_strobe, output, 1 bit: the 4094 STROBE, active high.
REQ-012 SHALL have port sr_miso, input, 1 bit: the QS output of the last 4094 in the chain.
REQ-013 SHALL have port readback, output, WIDTH bits: the previous chain contents. It exists only when SR_4094_READBACK_EN is defined.

Function
REQ-014 SHALL implement a state machine with states IDLE, SHIFT_LO, SHIFT_HI, STROBE and DONE.
REQ-015 IDLE: when start=1, SHALL load data into the shift register, clear the bit counter, set busy=1 on the next cycle and go to SHIFT_LO.
REQ-016 SHALL ignore start while busy=1; no queueing, and the shift register is unaffected.
REQ-017 SHIFT_LO: sr_clk=0 and sr_data=current MSB; after CLK_DIV cycles SHALL go to SHIFT_HI.
REQ-018 SHIFT_HI: sr_clk=1 with sr_data stable; after CLK_DIV cycles SHALL left-shift the register and increment the counter.
REQ-019 On leaving SHIFT_HI, SHALL go to STROBE if the counter equals WIDTH, else to SHIFT_LO.
REQ-020 SHALL shift MSB first, so data[WIDTH-1] ends up in the far end of the chain.
REQ-021 STROBE: sr_strobe=1 and sr_clk=0 for CLK_DIV cycles, then SHALL go to DONE.
REQ-022 DONE: done=1 for exactly one cycle and busy=0 from the following cycle; SHALL return to IDLE.
REQ-023 Busy duration SHALL be exactly 2*CLK_DIV*WIDTH + CLK_DIV + 1 cycles.
REQ-024 sr_data SHALL change only while sr_clk=0, never on the same cycle as a rising edge of sr_clk.
REQ-025 The divider counter SHALL be ceil(log2(CLK_DIV+1)) bits wide.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide.
REQ-027 Both counters SHALL reset to 0 on every state entry, with no wrap-around inside a state.
REQ-028 If start and done occur on the same cycle, start SHALL be ignored, because the state is not IDLE.

Reset
REQ-029 On rst=1, SHALL force IDLE with busy=0, done=0, sr_clk=0, sr_data=0, sr_strobe=0, counters=0 and readback=0, on the next clk edge.
REQ-030 A rst mid-transfer SHALL abort without asserting sr_strobe, so the 4094 outputs keep their last strobed value.

Configuration
REQ-031 With SR_4094_READBACK_EN defined, sr_miso SHALL be sampled on the last cycle of each SHIFT_HI and shifted LSB-in into a capture register.
REQ-032 With SR_4094_READBACK_EN defined, readback SHALL be updated from the capture register on DONE.
REQ-033 Without SR_4094_READBACK_EN, the readback port and capture register SHALL be absent and sr_miso SHALL be unused.

Structure
REQ-034 The state encoding and the default WIDTH/CLK_DIV constants SHALL live in shared package sr_4094_pkg.
REQ-035 A single sub-module, clk_divider_tick, SHALL produce the one-cycle tick every CLK_DIV cycles, restartable on state entry.

Verification
REQ-036 WIDTH=24, CLK_DIV=4, data=24'hA5C30F, start pulse -> 24 sr_clk rising edges; sr_data sampled at each edge = A5C30F MSB-first; one strobe of 4 cycles; busy=197 cycles; one done pulse.
REQ-037 A second start 10 cycles into a transfer with data=24'hFFFFFF -> the output bit stream is unchanged and exactly one done pulse occurs.
REQ-038 rst asserted at bit 12 -> all outputs 0 on the next cycle, sr_strobe never asserted, and a fresh start completes normally.
REQ-039 CLK_DIV=1, data=24'h000001 -> sr_clk period 2 cycles, busy=50 cycles, last bit=1, and sr_data never changes while sr_clk=1.
REQ-040 SR_4094_READBACK_EN defined, sr_miso loopback model (24-bit delay) preloaded 24'h123456, transfer 24'hABCDEF -> readback=24'h123456 after done; next transfer gives readback=24'hABCDEF.

Source files
------------

// File: rtl/sr_4094_pkg.sv
// sr_4094_pkg
// Shared definitions for the CD4094 chain shifter: FSM state encoding and
// default chain width / sr_clk half-period.
package sr_4094_pkg;

   localparam int unsigned SR_DEFAULT_WIDTH   = 24;
   localparam int unsigned SR_DEFAULT_CLK_DIV = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_LO = 3'd1,
      SHIFT_HI = 3'd2,
      STROBE   = 3'd3,
      DONE     = 3'd4
   } sr_state_t;

endpackage

// File: rtl/clk_divider_tick.sv
// clk_divider_tick
// Emits a one-cycle tick every CLK_DIV clk cycles. restart clears the count so
// that the first tick after a restart comes exactly CLK_DIV cycles later.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   restart  clear the count (asserted on the edge that enters a new state)
//   tick     high on the last cycle of each CLK_DIV-cycle period
module clk_divider_tick #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == TC);

   // Clearing on tick keeps the count from ever wrapping.
   always_ff @(posedge clk) begin
      if (rst || restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sr_4094_shifter.sv
// sr_4094_shifter
// Shifts a WIDTH-bit word MSB-first into a chain of CD4094 shift/latch
// registers, then pulses STROBE to move it onto the 4094 outputs.
// sr_clk runs at clk/(2*CLK_DIV); sr_data only moves while sr_clk is low.
//
// Build option SR_4094_READBACK_EN: adds the readback port. The bit returning
// on sr_miso (QS of the last 4094) is captured once per shifted bit, so after
// a transfer readback holds what the chain contained before that transfer.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (aborts without strobing)
//   start      one-cycle transfer request, accepted only in IDLE
//   data       word to shift, sampled with an accepted start
//   busy       transfer in progress
//   done       one-cycle completion pulse
//   sr_clk     4094 CLK
//   sr_data    4094 serial DATA
//   sr_strobe  4094 STROBE
//   sr_miso    QS from the last 4094 in the chain
//   readback   previous chain contents (SR_4094_READBACK_EN only)
//
// state    | meaning
// IDLE     | waiting for start, all 4094 lines low
// SHIFT_LO | sr_clk low, current MSB presented on sr_data
// SHIFT_HI | sr_clk high (4094 samples on the rise), sr_data held
// STROBE   | sr_clk low, STROBE high to latch the chain onto the outputs
// DONE     | one-cycle done pulse, then back to IDLE
module sr_4094_shifter
   import sr_4094_pkg::*;
#(
   parameter int unsigned WIDTH   = SR_DEFAULT_WIDTH,
   parameter int unsigned CLK_DIV = SR_DEFAULT_CLK_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             done,
   output logic             sr_clk,
   output logic             sr_data,
   output logic             sr_strobe,
   input  logic             sr_miso
`ifdef SR_4094_READBACK_EN
   ,
   output logic [WIDTH-1:0] readback
`endif
);

   localparam int unsigned BW = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

   sr_state_t        state;
   sr_state_t        state_next;
   logic [WIDTH-1:0] shift_reg;
   logic [BW-1:0]    bit_cnt;
   logic [BW-1:0]    bit_cnt_inc;
   logic             tick;
   logic             restart;
   logic             load;
   logic             shift;

   assign bit_cnt_inc = bit_cnt + 1'b1;

   // Restart the divider on every state change so each state lasts exactly
   // CLK_DIV cycles from its entry.
   assign restart = (state_next != state);

   clk_divider_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b1;
      done       = 1'b0;
      sr_clk     = 1'b0;
      sr_data    = 1'b0;
      sr_strobe  = 1'b0;
      load       = 1'b0;
      shift      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            sr_data = shift_reg[WIDTH-1];
            if (tick) begin
               state_next = SHIFT_HI;
            end
         end
         SHIFT_HI: begin
            sr_clk  = 1'b1;
            sr_data = shift_reg[WIDTH-1];
            if (tick) begin
               shift      = 1'b1;
               state_next = (bit_cnt_inc == BIT_LAST) ? STROBE : SHIFT_LO;
            end
         end
         STROBE: begin
            sr_strobe = 1'b1;
            if (tick) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   // The shift happens on the edge that drops sr_clk, so the next MSB
   // appears together with the falling edge, never with a rising one.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (load) begin
         shift_reg <= data;
         bit_cnt   <= '0;
      end else if (shift) begin
         shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
         bit_cnt   <= bit_cnt_inc;
      end
   end

`ifdef SR_4094_READBACK_EN
   logic [WIDTH-1:0] capture;

   always_ff @(posedge clk) begin
      if (rst) begin
         capture  <= '0;
         readback <= '0;
      end else begin
         if (shift) begin
            capture <= {capture[WIDTH-2:0], sr_miso};
         end
         if (state == DONE) begin
            readback <= capture;
         end
      end
   end
`else
   logic unused_miso;
   assign unused_miso = sr_miso;
`endif

endmodule

// File: tb/tb_sr_4094_shifter.sv
module tb_sr_4094_shifter;

   localparam int W  = 24;
   localparam int DA = 4;
   localparam int DB = 1;
   localparam int BUSY_A = 2 * DA * W + DA + 1;
   localparam int BUSY_B = 2 * DB * W + DB + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          start_a = 1'b0;
   logic [W-1:0]  data_a  = '0;
   logic          busy_a, done_a, sr_clk_a, sr_data_a, sr_strobe_a;
   logic          miso_a  = 1'b0;
   logic          start_b = 1'b0;
   logic [W-1:0]  data_b  = '0;
   logic          busy_b, done_b, sr_clk_b, sr_data_b, sr_strobe_b;
   logic          miso_b;
`ifdef SR_4094_READBACK_EN
   logic [W-1:0]  readback_a;
   logic [W-1:0]  readback_b;
`endif

   assign miso_b = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sr_4094_shifter #(.WIDTH(W), .CLK_DIV(DA)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .start     (start_a),
      .data      (data_a),
      .busy      (busy_a),
      .done      (done_a),
      .sr_clk    (sr_clk_a),
      .sr_data   (sr_data_a),
      .sr_strobe (sr_strobe_a),
      .sr_miso   (miso_a)
`ifdef SR_4094_READBACK_EN
      ,
      .readback  (readback_a)
`endif
   );

   sr_4094_shifter #(.WIDTH(W), .CLK_DIV(DB)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .start     (start_b),
      .data      (data_b),
      .busy      (busy_b),
      .done      (done_b),
      .sr_clk    (sr_clk_b),
      .sr_data   (sr_data_b),
      .sr_strobe (sr_strobe_b),
      .sr_miso   (miso_b)
`ifdef SR_4094_READBACK_EN
      ,
      .readback  (readback_b)
`endif
   );

   // Observer for DUT A: the bits a 4094 would clock in, plus a 4094-chain
   // model driving sr_miso (QS updated when sr_clk falls).
   bit          bits_a[$];
   int          busy_cnt_a = 0, strobe_cnt_a = 0, done_cnt_a = 0, hi_chg_a = 0;
   logic        prev_clk_a = 1'b0, prev_data_a = 1'b0;
   logic [W-1:0] chain_a = '0;
   logic        preload_req = 1'b0;
   logic [W-1:0] preload_val = '0;

   always @(negedge clk) begin
      if (preload_req) begin
         chain_a = preload_val;
         miso_a  = preload_val[W-1];
      end else begin
         if (sr_clk_a && !prev_clk_a) chain_a = {chain_a[W-2:0], sr_data_a};
         if (!sr_clk_a && prev_clk_a) miso_a = chain_a[W-1];
      end
      if (sr_clk_a && !prev_clk_a) bits_a.push_back(sr_data_a);
      if (sr_clk_a && (sr_data_a !== prev_data_a)) hi_chg_a++;
      if (busy_a) busy_cnt_a++;
      if (sr_strobe_a) strobe_cnt_a++;
      if (done_a) done_cnt_a++;
      prev_clk_a  = sr_clk_a;
      prev_data_a = sr_data_a;
   end

   bit   bits_b[$];
   int   rise_cyc_b[$];
   int   cyc_b = 0, busy_cnt_b = 0, strobe_cnt_b = 0, done_cnt_b = 0, hi_chg_b = 0;
   logic prev_clk_b = 1'b0, prev_data_b = 1'b0;

   always @(negedge clk) begin
      cyc_b++;
      if (sr_clk_b && !prev_clk_b) begin
         bits_b.push_back(sr_data_b);
         rise_cyc_b.push_back(cyc_b);
      end
      if (sr_clk_b && (sr_data_b !== prev_data_b)) hi_chg_b++;
      if (busy_b) busy_cnt_b++;
      if (sr_strobe_b) strobe_cnt_b++;
      if (done_b) done_cnt_b++;
      prev_clk_b  = sr_clk_b;
      prev_data_b = sr_data_b;
   end

   // Runs one transfer on DUT A; a second start with dup_d is issued dup_at
   // cycles in (0 = none). Returns what the observer saw during it.
   task automatic xfer_a(input logic [W-1:0] d, input int dup_at, input logic [W-1:0] dup_d,
                         output bit seen, output logic [W-1:0] word, output int nbits,
                         output int nbusy, output int nstrobe, output int ndone, output int nhi);
      int s_bits, s_busy, s_str, s_done, s_hi;
      s_bits = bits_a.size();
      s_busy = busy_cnt_a;
      s_str  = strobe_cnt_a;
      s_done = done_cnt_a;
      s_hi   = hi_chg_a;
      @(posedge clk); #1;
      start_a = 1'b1;
      data_a  = d;
      @(posedge clk); #1;
      start_a = 1'b0;
      data_a  = ~d;
      seen = 1'b0;
      for (int i = 1; i <= 400 && !seen; i++) begin
         @(posedge clk); #1;
         start_a = (i == dup_at);
         if (i == dup_at) data_a = dup_d;
         if (done_a) seen = 1'b1;
      end
      start_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nbits   = bits_a.size() - s_bits;
      nbusy   = busy_cnt_a - s_busy;
      nstrobe = strobe_cnt_a - s_str;
      ndone   = done_cnt_a - s_done;
      nhi     = hi_chg_a - s_hi;
      word    = '0;
      for (int i = 0; i < W; i++) begin
         if (s_bits + i < bits_a.size()) word = {word[W-2:0], bits_a[s_bits + i]};
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy_a, done_a, sr_clk_a, sr_data_a, sr_strobe_a} !== 5'b0)
         $display("FAIL reset_outputs_a: got %b expected 00000",
                  {busy_a, done_a, sr_clk_a, sr_data_a, sr_strobe_a});
      else n_pass++;
      n_checks++;
      if ({busy_b, done_b, sr_clk_b, sr_data_b, sr_strobe_b} !== 5'b0)
         $display("FAIL reset_outputs_b: got %b expected 00000",
                  {busy_b, done_b, sr_clk_b, sr_data_b, sr_strobe_b});
      else n_pass++;
`ifdef SR_4094_READBACK_EN
      n_checks++;
      if (readback_a !== '0) $display("FAIL reset_readback: got %h expected 000000", readback_a);
      else n_pass++;
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (busy_a !== 1'b0) $display("FAIL idle_after_reset: busy got %b expected 0", busy_a);
      else n_pass++;
   endtask

   task automatic test_pattern;
      bit seen; logic [W-1:0] word; int nb, nbusy, ns, nd, nh;
      xfer_a(24'hA5C30F, 0, '0, seen, word, nb, nbusy, ns, nd, nh);
      n_checks++;
      if (!seen) $display("FAIL pattern_timeout: done not seen within 400 cycles");
      else n_pass++;
      n_checks++;
      if (nb !== W) $display("FAIL pattern_edges: got %0d expected %0d", nb, W);
      else n_pass++;
      n_checks++;
      if (word !== 24'hA5C30F) $display("FAIL pattern_bits: got %h expected a5c30f", word);
      else n_pass++;
      n_checks++;
      if (ns !== DA) $display("FAIL pattern_strobe: got %0d cycles expected %0d", ns, DA);
      else n_pass++;
      n_checks++;
      if (nbusy !== BUSY_A) $display("FAIL pattern_busy: got %0d expected %0d", nbusy, BUSY_A);
      else n_pass++;
      n_checks++;
      if (nd !== 1) $display("FAIL pattern_done: got %0d pulses expected 1", nd);
      else n_pass++;
      n_checks++;
      if (nh !== 0) $display("FAIL pattern_data_while_high: got %0d changes expected 0", nh);
      else n_pass++;
   endtask

   task automatic test_random;
      bit seen; logic [W-1:0] word, d; int nb, nbusy, ns, nd, nh;
      for (int k = 0; k < 4; k++) begin
         d = W'($urandom());
         xfer_a(d, 0, '0, seen, word, nb, nbusy, ns, nd, nh);
         n_checks++;
         if (word !== d || nb !== W) $display("FAIL random_bits[%0d]: got %h/%0d bits expected %h/%0d", k, word, nb, d, W);
         else n_pass++;
         n_checks++;
         if (nbusy !== BUSY_A || nd !== 1 || ns !== DA)
            $display("FAIL random_timing[%0d]: busy %0d done %0d strobe %0d expected %0d 1 %0d", k, nbusy, nd, ns, BUSY_A, DA);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      bit seen; logic [W-1:0] word, d; int nb, nbusy, ns, nd, nh;
      d = W'($urandom()) & 24'h7FFFFE;
      xfer_a(d, 10, 24'hFFFFFF, seen, word, nb, nbusy, ns, nd, nh);
      n_checks++;
      if (word !== d || nb !== W) $display("FAIL b2b_bits: got %h/%0d bits expected %h/%0d", word, nb, d, W);
      else n_pass++;
      n_checks++;
      if (nd !== 1) $display("FAIL b2b_done: got %0d pulses expected 1", nd);
      else n_pass++;
      n_checks++;
      if (nbusy !== BUSY_A) $display("FAIL b2b_busy: got %0d expected %0d", nbusy, BUSY_A);
      else n_pass++;
      n_checks++;
      if (busy_a !== 1'b0) $display("FAIL b2b_no_queue: busy got %b expected 0", busy_a);
      else n_pass++;
   endtask

   task automatic test_start_on_done;
      bit seen;
      @(posedge clk); #1;
      start_a = 1'b1;
      data_a  = W'($urandom());
      @(posedge clk); #1;
      start_a = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(posedge clk); #1;
         if (done_a) seen = 1'b1;
      end
      n_checks++;
      if (!seen) $display("FAIL start_on_done_timeout: done not seen within 400 cycles");
      else n_pass++;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy_a !== 1'b0) $display("FAIL start_on_done: busy got %b expected 0", busy_a);
      else n_pass++;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset_mid;
      bit seen; logic [W-1:0] word, d; int nb, nbusy, ns, nd, nh, s_bits, s_str;
      s_bits = bits_a.size();
      s_str  = strobe_cnt_a;
      @(posedge clk); #1;
      start_a = 1'b1;
      data_a  = W'($urandom());
      @(posedge clk); #1;
      start_a = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (bits_a.size() - s_bits >= 12) seen = 1'b1;
      end
      n_checks++;
      if (!seen) $display("FAIL reset_mid_timeout: 12 bits not seen within 400 cycles");
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy_a, done_a, sr_clk_a, sr_data_a, sr_strobe_a} !== 5'b0)
         $display("FAIL reset_mid_outputs: got %b expected 00000",
                  {busy_a, done_a, sr_clk_a, sr_data_a, sr_strobe_a});
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      n_checks++;
      if (strobe_cnt_a !== s_str) $display("FAIL reset_mid_no_strobe: got %0d strobe cycles expected 0", strobe_cnt_a - s_str);
      else n_pass++;
      d = W'($urandom());
      xfer_a(d, 0, '0, seen, word, nb, nbusy, ns, nd, nh);
      n_checks++;
      if (word !== d || nb !== W) $display("FAIL reset_mid_fresh_bits: got %h/%0d bits expected %h/%0d", word, nb, d, W);
      else n_pass++;
      n_checks++;
      if (nbusy !== BUSY_A || nd !== 1 || ns !== DA)
         $display("FAIL reset_mid_fresh_timing: busy %0d done %0d strobe %0d expected %0d 1 %0d", nbusy, nd, ns, BUSY_A, DA);
      else n_pass++;
   endtask

   task automatic test_clkdiv1;
      bit seen; logic [W-1:0] word; int s_bits, s_busy, s_str, s_done, s_hi, nb, bad;
      s_bits = bits_b.size();
      s_busy = busy_cnt_b;
      s_str  = strobe_cnt_b;
      s_done = done_cnt_b;
      s_hi   = hi_chg_b;
      @(posedge clk); #1;
      start_b = 1'b1;
      data_b  = 24'h000001;
      @(posedge clk); #1;
      start_b = 1'b0;
      data_b  = 24'hFFFFFE;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk); #1;
         if (done_b) seen = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (!seen) $display("FAIL div1_timeout: done not seen within 200 cycles");
      else n_pass++;
      nb = bits_b.size() - s_bits;
      word = '0;
      bad  = 0;
      for (int i = 0; i < W; i++) begin
         if (s_bits + i < bits_b.size()) begin
            word = {word[W-2:0], bits_b[s_bits + i]};
            if (i > 0 && rise_cyc_b[s_bits + i] - rise_cyc_b[s_bits + i - 1] != 2 * DB) bad++;
         end
      end
      n_checks++;
      if (nb !== W || word !== 24'h000001) $display("FAIL div1_bits: got %h/%0d bits expected 000001/%0d", word, nb, W);
      else n_pass++;
      n_checks++;
      if (word[0] !== 1'b1) $display("FAIL div1_last_bit: got %b expected 1", word[0]);
      else n_pass++;
      n_checks++;
      if (bad !== 0) $display("FAIL div1_period: got %0d edges not 2 cycles apart expected 0", bad);
      else n_pass++;
      n_checks++;
      if (busy_cnt_b - s_busy !== BUSY_B) $display("FAIL div1_busy: got %0d expected %0d", busy_cnt_b - s_busy, BUSY_B);
      else n_pass++;
      n_checks++;
      if (hi_chg_b - s_hi !== 0) $display("FAIL div1_data_while_high: got %0d changes expected 0", hi_chg_b - s_hi);
      else n_pass++;
      n_checks++;
      if (strobe_cnt_b - s_str !== DB || done_cnt_b - s_done !== 1)
         $display("FAIL div1_strobe_done: strobe %0d done %0d expected %0d 1", strobe_cnt_b - s_str, done_cnt_b - s_done, DB);
      else n_pass++;
   endtask

`ifdef SR_4094_READBACK_EN
   task automatic test_readback;
      bit seen; logic [W-1:0] word; int nb, nbusy, ns, nd, nh;
      @(posedge clk); #1;
      preload_val = 24'h123456;
      preload_req = 1'b1;
      @(posedge clk); #1;
      preload_req = 1'b0;
      xfer_a(24'hABCDEF, 0, '0, seen, word, nb, nbusy, ns, nd, nh);
      n_checks++;
      if (readback_a !== 24'h123456) $display("FAIL readback_first: got %h expected 123456", readback_a);
      else n_pass++;
      xfer_a(W'($urandom()), 0, '0, seen, word, nb, nbusy, ns, nd, nh);
      n_checks++;
      if (readback_a !== 24'hABCDEF) $display("FAIL readback_second: got %h expected abcdef", readback_a);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_pattern();
      test_random();
      test_back_to_back();
      test_start_on_done();
      test_reset_mid();
      test_clkdiv1();
`ifdef SR_4094_READBACK_EN
      test_readback();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
